// File: rtl/ghr_checkpoint_ctrl.sv
// Speculative global-history register with per-branch checkpoint FIFO and EX-stage repair.
// Optional performance counters are built when GHR_CKPT_PERF_EN is defined.
module ghr_checkpoint_ctrl #(
   parameter int GHR_WIDTH  = 8,
   parameter int CKPT_DEPTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 if1_br_valid,
   input  logic                 if1_pred_taken,
   output logic [GHR_WIDTH-1:0] ghr,
   output logic                 ckpt_full,
   input  logic                 ex_resolve,
   input  logic                 ex_taken,
   output logic [GHR_WIDTH-1:0] ex_ghr,
   output logic                 pht_we,
   output logic                 pht_branched,
   output logic                 ex_mispredict,
   input  logic                 flush,
   output logic [31:0]          perf_br_cnt,
   output logic [31:0]          perf_miss_cnt
);

   localparam int PW = $clog2(CKPT_DEPTH);
   localparam int CW = PW + 1;

   logic [GHR_WIDTH-1:0] r_spec_ghr;
   logic [GHR_WIDTH-1:0] r_commit_ghr;
   logic [GHR_WIDTH-1:0] r_fifo_ghr [CKPT_DEPTH];
   logic                 r_fifo_pred [CKPT_DEPTH];
   logic [PW-1:0]        r_head;
   logic [PW-1:0]        r_tail;
   logic [CW-1:0]        r_count;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_mispredict;
   logic [GHR_WIDTH-1:0] w_head_ghr;
   logic [GHR_WIDTH-1:0] w_commit_nxt;
   logic [PW-1:0]        w_head_inc;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == CW'(CKPT_DEPTH));
   assign w_head_ghr   = r_fifo_ghr[r_head];
   assign w_pop        = ex_resolve & ~w_empty;
   assign w_mispredict = w_pop & (ex_taken != r_fifo_pred[r_head]);
   // A push is lost when the front end is being redirected this very cycle.
   assign w_push       = if1_br_valid & ~w_full & ~flush & ~w_mispredict;
   assign w_head_inc   = r_head + PW'(1);
   assign w_commit_nxt = w_pop ? {r_commit_ghr[GHR_WIDTH-2:0], ex_taken} : r_commit_ghr;

   assign ghr           = r_spec_ghr;
   assign ckpt_full     = w_full;
   assign ex_ghr        = w_empty ? r_commit_ghr : w_head_ghr;
   assign pht_we        = w_pop;
   assign pht_branched  = ex_taken;
   assign ex_mispredict = w_mispredict;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_ghr[r_tail]  <= r_spec_ghr;
         r_fifo_pred[r_tail] <= if1_pred_taken;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_spec_ghr   <= '0;
         r_commit_ghr <= '0;
         r_head       <= '0;
         r_tail       <= '0;
         r_count      <= '0;
      end else begin
         r_commit_ghr <= w_commit_nxt;
         if (flush) begin
            r_spec_ghr <= w_commit_nxt;
            r_count    <= '0;
            r_head     <= w_pop ? w_head_inc : r_head;
            r_tail     <= w_pop ? w_head_inc : r_head;
         end else if (w_mispredict) begin
            // Everything behind the head was fetched down the wrong path.
            r_spec_ghr <= {w_head_ghr[GHR_WIDTH-2:0], ex_taken};
            r_count    <= '0;
            r_head     <= w_head_inc;
            r_tail     <= w_head_inc;
         end else begin
            if (w_push) begin
               r_spec_ghr <= {r_spec_ghr[GHR_WIDTH-2:0], if1_pred_taken};
               r_tail     <= r_tail + PW'(1);
            end
            if (w_pop) begin
               r_head <= w_head_inc;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + CW'(1);
               2'b01:   r_count <= r_count - CW'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end

`ifdef GHR_CKPT_PERF_EN
   logic [31:0] r_perf_br;
   logic [31:0] r_perf_miss;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_perf_br   <= '0;
         r_perf_miss <= '0;
      end else begin
         if (w_pop && (r_perf_br != 32'hFFFF_FFFF)) begin
            r_perf_br <= r_perf_br + 32'd1;
         end
         if (w_mispredict && (r_perf_miss != 32'hFFFF_FFFF)) begin
            r_perf_miss <= r_perf_miss + 32'd1;
         end
      end
   end

   assign perf_br_cnt   = r_perf_br;
   assign perf_miss_cnt = r_perf_miss;
`else
   assign perf_br_cnt   = 32'd0;
   assign perf_miss_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_ghr_checkpoint_ctrl.sv
// Directed scoreboard bench for ghr_checkpoint_ctrl (push, fill, mispredict, flush, perf counters).
module tb_ghr_checkpoint_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         if1_br_valid;
   logic         if1_pred_taken;
   logic         ex_resolve;
   logic         ex_taken;
   logic         flush;
   logic [W-1:0] ghr;
   logic [W-1:0] ex_ghr;
   logic         ckpt_full;
   logic         pht_we;
   logic         pht_branched;
   logic         ex_mispredict;
   logic [31:0]  perf_br_cnt;
   logic [31:0]  perf_miss_cnt;

   int          n_pass  = 0;
   int          n_fail  = 0;
   int          n_total = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   ghr_checkpoint_ctrl #(.GHR_WIDTH(W), .CKPT_DEPTH(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .if1_br_valid  (if1_br_valid),
      .if1_pred_taken(if1_pred_taken),
      .ghr           (ghr),
      .ckpt_full     (ckpt_full),
      .ex_resolve    (ex_resolve),
      .ex_taken      (ex_taken),
      .ex_ghr        (ex_ghr),
      .pht_we        (pht_we),
      .pht_branched  (pht_branched),
      .ex_mispredict (ex_mispredict),
      .flush         (flush),
      .perf_br_cnt   (perf_br_cnt),
      .perf_miss_cnt (perf_miss_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic p, input logic r, input logic t, input logic f);
      if1_br_valid   = v;
      if1_pred_taken = p;
      ex_resolve     = r;
      ex_taken       = t;
      flush          = f;
   endtask

   task automatic expv(input logic [31:0] v);
      exp_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      logic [31:0] e;
      n_total++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %h, scoreboard had no expected value", tag, obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e) n_pass++;
         else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
         end
      end
   endtask

   task automatic push_n(input int n, input logic p);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, p, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a resolve request held high: the empty FIFO must ignore it.
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      expv(32'h0); expv(32'h0); expv(32'h0); expv(32'h0);
      expv(32'h0); expv(32'h0); expv(32'h0); expv(32'h0);
      chk("rst_ghr", 32'(ghr));
      chk("rst_ex_ghr", 32'(ex_ghr));
      chk("rst_full", 32'(ckpt_full));
      chk("rst_pht_we", 32'(pht_we));
      chk("rst_misp", 32'(ex_mispredict));
      chk("rst_branched", 32'(pht_branched));
      chk("rst_perf_br", perf_br_cnt);
      chk("rst_perf_miss", perf_miss_cnt);

      // Push preds 1,0,1
      rst_n = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #4; expv(32'h00); chk("t1_ghr0", 32'(ghr));
      tick(); expv(32'h01); chk("t1_ghr1", 32'(ghr));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expv(32'h02); chk("t1_ghr2", 32'(ghr));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      tick(); expv(32'h05); chk("t1_ghr3", 32'(ghr));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #4; expv(32'h00); chk("t1_ex_ghr_head", 32'(ex_ghr));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); expv(32'h00); chk("t1_flush_ghr", 32'(ghr));

      // Fill to full, refuse a 9th push, then pop while full
      push_n(7, 1'b1);
      expv(32'h0); chk("t2_full_at7", 32'(ckpt_full));
      push_n(1, 1'b1);
      expv(32'h1); chk("t2_full_at8", 32'(ckpt_full));
      expv(32'hFF); chk("t2_ghr_full", 32'(ghr));
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick(); expv(32'hFF); chk("t2_refused_ghr", 32'(ghr));
      expv(32'h1); chk("t2_still_full", 32'(ckpt_full));
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h1); chk("t2_pht_we", 32'(pht_we));
      expv(32'h0); chk("t2_misp", 32'(ex_mispredict));
      expv(32'h00); chk("t2_ex_ghr", 32'(ex_ghr));
      expv(32'h1); chk("t2_branched", 32'(pht_branched));
      tick(); expv(32'hFF); chk("t2_pop_full_ghr", 32'(ghr));
      expv(32'h0); chk("t2_full_drop", 32'(ckpt_full));
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h01); chk("t2_ex_ghr2", 32'(ex_ghr));
      tick(); expv(32'hFE); chk("t2_push_pop_ghr", 32'(ghr));
      expv(32'h0); chk("t2_count_kept", 32'(ckpt_full));
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); expv(32'h03); chk("t2_flush_commit", 32'(ghr));

      // Mid-operation reset with a checkpoint in flight
      push_n(1, 1'b1);
      expv(32'h07); chk("t3_pre_rst_ghr", 32'(ghr));
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      tick(); expv(32'h00); chk("t3_rst_ghr", 32'(ghr));
      expv(32'h0); chk("t3_rst_pht_we", 32'(pht_we));
      rst_n = 1'b1;

      // Mispredict of the oldest branch
      push_n(3, 1'b1);
      expv(32'h07); chk("t3_ghr_111", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #4; expv(32'h1); chk("t3_misp", 32'(ex_mispredict));
      expv(32'h1); chk("t3_pht_we", 32'(pht_we));
      expv(32'h00); chk("t3_ex_ghr", 32'(ex_ghr));
      tick(); expv(32'h00); chk("t3_repair_ghr", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h0); chk("t3_empty_pht_we", 32'(pht_we));
      expv(32'h0); chk("t3_empty_misp", 32'(ex_mispredict));
      expv(32'h00); chk("t3_commit", 32'(ex_ghr));

      // Push in the same cycle as a mispredicting resolve
      push_n(1, 1'b0);
      push_n(1, 1'b1);
      expv(32'h01); chk("t4_ghr", 32'(ghr));
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h1); chk("t4_misp", 32'(ex_mispredict));
      tick(); expv(32'h01); chk("t4_repair_ghr", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h0); chk("t4_dropped_push", 32'(pht_we));
      expv(32'h01); chk("t4_commit", 32'(ex_ghr));

      // Correct resolves then flush with entries in flight
      do_reset();
      push_n(5, 1'b1);
      expv(32'h1F); chk("t5_ghr", 32'(ghr));
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
         #4; expv(32'((1 << i) - 1)); chk("t5_ex_ghr", 32'(ex_ghr));
         expv(32'h1); chk("t5_pht_we", 32'(pht_we));
         expv(32'h0); chk("t5_misp", 32'(ex_mispredict));
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick(); expv(32'h07); chk("t5_flush_ghr", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h0); chk("t5_empty_pht_we", 32'(pht_we));
      expv(32'h07); chk("t5_empty_ex_ghr", 32'(ex_ghr));
      push_n(1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      #4; expv(32'h1); chk("t5_flush_res_we", 32'(pht_we));
      tick(); expv(32'h0F); chk("t5_flush_res_ghr", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h0); chk("t5_after_flush_we", 32'(pht_we));

      // Performance counters: 5 resolves, 2 mispredicted
      do_reset();
      push_n(3, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h0); chk("t6_misp_a", 32'(ex_mispredict));
      tick();
      #4; expv(32'h0); chk("t6_misp_b", 32'(ex_mispredict));
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #4; expv(32'h1); chk("t6_misp_c", 32'(ex_mispredict));
      tick(); expv(32'h06); chk("t6_repair_ghr", 32'(ghr));
      push_n(2, 1'b0);
      expv(32'h18); chk("t6_ghr", 32'(ghr));
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #4; expv(32'h0); chk("t6_misp_d", 32'(ex_mispredict));
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      #4; expv(32'h1); chk("t6_misp_e", 32'(ex_mispredict));
      tick(); expv(32'h19); chk("t6_repair_ghr2", 32'(ghr));
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef GHR_CKPT_PERF_EN
      expv(32'd5); expv(32'd2);
`else
      expv(32'd0); expv(32'd0);
`endif
      chk("t6_perf_br", perf_br_cnt);
      chk("t6_perf_miss", perf_miss_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
